// File: rtl/apagador_solicitudes_param.sv
// Elevator request latch and clear stage: holds hall/cabin calls per floor, clears the calls
// served at a stop and blocks re-requests of those calls while the doors dwell open.
module apagador_solicitudes_param #(
  parameter int FLOORS = 4,
  parameter int FW     = 2,
  parameter int DWELL  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] hall_up_req,
  input  logic [FLOORS-1:0] hall_dn_req,
  input  logic [FLOORS-1:0] car_req,
  input  logic [FLOORS-1:0] car_cancel,
  input  logic              serve,
  input  logic [FW-1:0]     serve_floor,
  input  logic              serve_dir,
  input  logic [FW-1:0]     cur_floor,
  output logic [FLOORS-1:0] hall_up_pend,
  output logic [FLOORS-1:0] hall_dn_pend,
  output logic [FLOORS-1:0] car_pend,
  output logic [FW+2:0]     pending,
  output logic              any_above,
  output logic              any_below,
  output logic              door_busy
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);
  // The top floor has no up button and the bottom floor has no down button.
  localparam logic [FLOORS-1:0] UP_EXIST = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_EXIST = {{(FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic {ST_IDLE, ST_DWELL} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [FW-1:0]       r_floor;
  logic                r_dir;
  logic                r_busy;
  logic [FLOORS-1:0]   r_up, r_dn, r_car;
  logic [FLOORS-1:0]   r_sup_up, r_sup_dn, r_sup_car;

  logic [FLOORS-1:0]   w_hit;
  logic                w_valid;
  logic                w_accept;
  logic                w_reload;
  logic                w_beyond;
  logic [FLOORS-1:0]   w_clr_up, w_clr_dn, w_clr_car;
  logic [FLOORS-1:0]   w_rev_up, w_rev_dn;
  logic [FLOORS-1:0]   w_left;
  logic [FLOORS-1:0]   w_kill_up, w_kill_dn, w_kill_car;
  logic [FLOORS-1:0]   w_allow_up, w_allow_dn, w_allow_car;
  logic [FLOORS-1:0]   w_nxt_up, w_nxt_dn, w_nxt_car;
  logic [FLOORS-1:0]   w_all;
  logic [FW+2:0]       w_count;
  logic                w_above, w_below;

  always_comb begin
    w_hit = '0;
    for (int f = 0; f < FLOORS; f++) begin
      w_hit[f] = (serve_floor == FW'(f));
    end
    w_valid  = (int'(serve_floor) < FLOORS);
    w_accept = (r_state == ST_IDLE) && serve && w_valid;
    w_reload = (r_state == ST_DWELL) && serve &&
               (serve_floor == r_floor) && (serve_dir == r_dir);

    // End floors own a single hall call, so it is served whatever the direction.
    w_clr_up  = w_hit & UP_EXIST & {FLOORS{serve_dir || (serve_floor == '0)}};
    w_clr_dn  = w_hit & DN_EXIST & {FLOORS{!serve_dir || (int'(serve_floor) == FLOORS-1)}};
    w_clr_car = w_hit;

    // Reversal looks only at what survives this stop, not at requests arriving now.
    w_left   = (r_up & ~w_clr_up) | (r_dn & ~w_clr_dn) | (r_car & ~w_clr_car);
    w_beyond = 1'b0;
    for (int g = 0; g < FLOORS; g++) begin
      if (w_left[g] && (serve_dir ? (g > int'(serve_floor)) : (g < int'(serve_floor))))
        w_beyond = 1'b1;
    end
    w_rev_up = w_hit & UP_EXIST & {FLOORS{!serve_dir && !w_beyond}};
    w_rev_dn = w_hit & DN_EXIST & {FLOORS{serve_dir && !w_beyond}};

    w_kill_up  = w_accept ? (w_clr_up | w_rev_up) : '0;
    w_kill_dn  = w_accept ? (w_clr_dn | w_rev_dn) : '0;
    w_kill_car = w_accept ? w_clr_car : '0;

    w_allow_up  = (r_state == ST_DWELL) ? ~r_sup_up  : '1;
    w_allow_dn  = (r_state == ST_DWELL) ? ~r_sup_dn  : '1;
    w_allow_car = (r_state == ST_DWELL) ? ~r_sup_car : '1;

    w_nxt_up  = (r_up  | (hall_up_req & w_allow_up)) & ~w_kill_up & UP_EXIST;
    w_nxt_dn  = (r_dn  | (hall_dn_req & w_allow_dn)) & ~w_kill_dn & DN_EXIST;
    w_nxt_car = (r_car | (car_req & w_allow_car)) & ~car_cancel & ~w_kill_car;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_floor   <= '0;
      r_dir     <= 1'b0;
      r_busy    <= 1'b0;
      r_up      <= '0;
      r_dn      <= '0;
      r_car     <= '0;
      r_sup_up  <= '0;
      r_sup_dn  <= '0;
      r_sup_car <= '0;
    end else begin
      r_up  <= w_nxt_up;
      r_dn  <= w_nxt_dn;
      r_car <= w_nxt_car;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_DWELL;
            r_cnt     <= CNT_LOAD;
            r_floor   <= serve_floor;
            r_dir     <= serve_dir;
            r_busy    <= 1'b1;
            r_sup_up  <= w_clr_up | w_rev_up;
            r_sup_dn  <= w_clr_dn | w_rev_dn;
            r_sup_car <= w_clr_car;
          end
        end
        ST_DWELL: begin
          // A repeat of the same stop keeps the doors open; it takes priority over expiry.
          if (w_reload) begin
            r_cnt <= CNT_LOAD;
          end else if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_count = '0;
    w_above = 1'b0;
    w_below = 1'b0;
    w_all   = r_up | r_dn | r_car;
    for (int f = 0; f < FLOORS; f++) begin
      w_count = w_count + (FW+3)'(r_up[f]) + (FW+3)'(r_dn[f]) + (FW+3)'(r_car[f]);
      if (w_all[f] && (f > int'(cur_floor))) w_above = 1'b1;
      if (w_all[f] && (f < int'(cur_floor))) w_below = 1'b1;
    end
  end

  assign hall_up_pend = r_up;
  assign hall_dn_pend = r_dn;
  assign car_pend     = r_car;
  assign pending      = w_count;
  assign any_above    = w_above;
  assign any_below    = w_below;
  assign door_busy    = r_busy;

endmodule
